// File: rtl/approx_err_sweep_monitor.sv
// Exhaustive error sweep of one approximate abs_diff circuit against its exact value.
// Optional err_sum accumulator: define APPROX_ERR_SWEEP_SUM_EN.
module approx_err_sweep_monitor #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 3,
    parameter int ET    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [IN_W-1:0]  stim,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [OUT_W-1:0] max_err,
    output logic [IN_W-1:0]  worst_vec,
`ifdef APPROX_ERR_SWEEP_SUM_EN
    output logic [OUT_W+IN_W-1:0] err_sum,
`endif
    output logic [IN_W:0]    viol_cnt
);

    localparam int HW = IN_W / 2;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    state_t state;

    logic [HW-1:0]    op_a;
    logic [HW-1:0]    op_b;
    logic [HW-1:0]    diff_ab;
    logic [OUT_W-1:0] exact;
    logic [OUT_W-1:0] err;
    logic             viol;
    logic             last_vec;
    logic [IN_W:0]    viol_next;

    always_comb begin
        op_a      = stim[HW-1:0];
        op_b      = stim[IN_W-1:HW];
        diff_ab   = (op_a >= op_b) ? (op_a - op_b) : (op_b - op_a);
        exact     = OUT_W'(diff_ab);
        err       = (dut_out >= exact) ? (dut_out - exact) : (exact - dut_out);
        viol      = (int'(err) > ET);
        last_vec  = (stim == {IN_W{1'b1}});
        viol_next = viol_cnt + {{IN_W{1'b0}}, viol};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            stim      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            max_err   <= '0;
            worst_vec <= '0;
            viol_cnt  <= '0;
`ifdef APPROX_ERR_SWEEP_SUM_EN
            err_sum   <= '0;
`endif
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= DRIVE;
                        stim      <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        max_err   <= '0;
                        worst_vec <= '0;
                        viol_cnt  <= '0;
`ifdef APPROX_ERR_SWEEP_SUM_EN
                        err_sum   <= '0;
`endif
                    end
                end
                DRIVE: begin
                    state <= SAMPLE;
                end
                SAMPLE: begin
                    // Strict compare so ties keep the earliest vector
                    if (err > max_err) begin
                        max_err   <= err;
                        worst_vec <= stim;
                    end
                    viol_cnt <= viol_next;
`ifdef APPROX_ERR_SWEEP_SUM_EN
                    err_sum  <= err_sum + (OUT_W+IN_W)'(err);
`endif
                    // Terminal check precedes increment, so stim never wraps
                    if (last_vec) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (viol_next == '0);
                    end else begin
                        stim  <= stim + 1'b1;
                        state <= DRIVE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_approx_err_sweep_monitor.sv
// Directed bench for approx_err_sweep_monitor with loopback/stuck approximations.
// Optional err_sum checks follow APPROX_ERR_SWEEP_SUM_EN.
module tb_approx_err_sweep_monitor;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] stim;
    logic [2:0] dut_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] max_err;
    logic [3:0] worst_vec;
    logic [4:0] viol_cnt;
`ifdef APPROX_ERR_SWEEP_SUM_EN
    logic [6:0] err_sum;
`endif

    int passed = 0;
    int total  = 0;
    int cyc;
    int mode;

    approx_err_sweep_monitor #(.IN_W(4), .OUT_W(3), .ET(2)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stim      (stim),
        .dut_out   (dut_out),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .max_err   (max_err),
        .worst_vec (worst_vec),
`ifdef APPROX_ERR_SWEEP_SUM_EN
        .err_sum   (err_sum),
`endif
        .viol_cnt  (viol_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0: exact |A-B|, 1: stuck at zero, 2: stuck at max
    always_comb begin
        logic [1:0] a;
        logic [1:0] b;
        a = stim[1:0];
        b = stim[3:2];
        dut_out = 3'b000;
        case (mode)
            0: dut_out = (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
            1: dut_out = 3'b000;
            default: dut_out = 3'b111;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int s1, input int s2, output int n);
        n = 0;
        while (!done && n < 100) begin
            start = (n == s1 || n == s2);
            tick();
            n++;
        end
        start = 1'b0;
    endtask

    task automatic chk_res(input string tag, input int me, input int wv,
                           input int vc, input int ps, input int es);
        chk({tag, "_max"},  32'(max_err),   32'(me));
        chk({tag, "_worst"}, 32'(worst_vec), 32'(wv));
        chk({tag, "_viol"}, 32'(viol_cnt),  32'(vc));
        chk({tag, "_pass"}, 32'(pass),      32'(ps));
        chk({tag, "_busy"}, 32'(busy),      32'd0);
        chk({tag, "_stim"}, 32'(stim),      32'd15);
`ifdef APPROX_ERR_SWEEP_SUM_EN
        chk({tag, "_sum"},  32'(err_sum),   32'(es));
`else
        if (es < 0) chk({tag, "_sum"}, 32'(es), 32'd0);
`endif
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = 0;
        tick();
        tick();
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_pass",  32'(pass),      32'd0);
        chk("rst_stim",  32'(stim),      32'd0);
        chk("rst_max",   32'(max_err),   32'd0);
        chk("rst_worst", 32'(worst_vec), 32'd0);
        chk("rst_viol",  32'(viol_cnt),  32'd0);
        rst = 1'b0;
        tick();

        // Loopback
        mode = 0;
        pulse_start();
        chk("lb_busy_start", 32'(busy), 32'd1);
        wait_done(-1, -1, cyc);
        chk("lb_cycles", 32'(cyc), 32'd32);
        chk("lb_done", 32'(done), 32'd1);
        chk_res("lb", 0, 0, 0, 1, 0);

        // Stuck-zero
        mode = 1;
        pulse_start();
        wait_done(-1, -1, cyc);
        chk("sz_cycles", 32'(cyc), 32'd32);
        chk_res("sz", 3, 3, 2, 0, 20);

        // Stuck-max
        mode = 2;
        pulse_start();
        wait_done(-1, -1, cyc);
        chk("sm_cycles", 32'(cyc), 32'd32);
        chk_res("sm", 7, 0, 16, 0, 92);
        tick();
        tick();
        chk("sm_hold_done", 32'(done), 32'd1);
        chk("sm_hold_max", 32'(max_err), 32'd7);

        // Mid-sweep reset at cycle 10
        pulse_start();
        for (int i = 0; i < 9; i++) tick();
        chk("mr_busy_before", 32'(busy), 32'd1);
        chk("mr_max_before", 32'(max_err), 32'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_busy",  32'(busy),      32'd0);
        chk("mr_done",  32'(done),      32'd0);
        chk("mr_max",   32'(max_err),   32'd0);
        chk("mr_worst", 32'(worst_vec), 32'd0);
        chk("mr_viol",  32'(viol_cnt),  32'd0);
        chk("mr_stim",  32'(stim),      32'd0);
        tick();
        tick();
        chk("mr_idle_busy", 32'(busy), 32'd0);
        pulse_start();
        wait_done(-1, -1, cyc);
        chk("mr_cycles", 32'(cyc), 32'd32);
        chk_res("mr", 7, 0, 16, 0, 92);

        // Start while busy at cycles 5 and 17
        mode = 1;
        pulse_start();
        wait_done(4, 16, cyc);
        chk("sb_cycles", 32'(cyc), 32'd32);
        chk_res("sb", 3, 3, 2, 0, 20);

        // Restart from DONE into loopback
        mode = 0;
        pulse_start();
        chk("rs_clr_max",   32'(max_err),   32'd0);
        chk("rs_clr_worst", 32'(worst_vec), 32'd0);
        chk("rs_clr_viol",  32'(viol_cnt),  32'd0);
        chk("rs_clr_done",  32'(done),      32'd0);
        chk("rs_clr_stim",  32'(stim),      32'd0);
        chk("rs_clr_busy",  32'(busy),      32'd1);
        wait_done(-1, -1, cyc);
        chk("rs_cycles", 32'(cyc), 32'd32);
        chk_res("rs", 0, 0, 0, 1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/approx_err_sweep_monitor.md
Name: approx_err_sweep_monitor

Overview:
- Sequential verification stage that wraps one approximate combinational circuit from the synthesis flow.
- Upstream role: exhaustively drives every input vector into the approximate circuit.
- Downstream role: consumes the circuit outputs, computes the exact absolute difference internally, and reports max error, violation count and worst vector against the error threshold.
- Used in FPGA/emulation sign-off of generated abs_diff approximations.

Parameters:
- IN_W, 4, total DUT input bits; even; operand A = stim[IN_W/2-1:0], operand B = stim[IN_W-1:IN_W/2].
- OUT_W, 3, DUT output bits; must satisfy OUT_W >= IN_W/2.
- ET, 2, error threshold; a vector violates when err > ET.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  begin a sweep; sampled in IDLE or DONE only.
- stim  output  IN_W  vector driven to the approximate circuit inputs (bit i -> in<i>).
- dut_out  input  OUT_W  approximate circuit outputs (bit j <- out<j>); combinational from stim.
- busy  output  1  high during DRIVE/SAMPLE.
- done  output  1  high (level) in DONE until next start or reset.
- pass  output  1  valid when done; 1 iff viol_cnt == 0.
- max_err  output  OUT_W  largest err seen in the sweep.
- worst_vec  output  IN_W  first stim value that produced max_err.
- viol_cnt  output  IN_W+1  number of vectors with err > ET.

Behaviour:
- Reset: the block is synchronous, active-high on rst. State goes to IDLE. stim, max_err, worst_vec and viol_cnt go to 0. busy, done and pass go to 0.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: on start, go to DRIVE. At the same time set stim=0 and clear max_err, worst_vec and viol_cnt.
- DRIVE: one cycle; stim is held stable so the DUT settles; go to SAMPLE.
- SAMPLE: register the result for the current stim. Then:
  - if stim == 2^IN_W-1, go to DONE;
  - otherwise increment stim and go to DRIVE.
- Sweep length: 2 cycles per vector, 2^IN_W vectors. done rises 2*2^IN_W cycles after the start cycle (32 cycles at defaults).
- Arithmetic, evaluated in SAMPLE:
  - exact = |A - B|, zero-extended to OUT_W.
  - err = |dut_out - exact|, unsigned, OUT_W bits; no overflow since both are < 2^OUT_W.
- Update rules, applied in SAMPLE:
  - if err > max_err: max_err <= err and worst_vec <= stim. Ties keep the earlier vector.
  - if err > ET: viol_cnt increments. Width IN_W+1 holds the full count 2^IN_W without wrap.
- DONE: done=1 and pass = (viol_cnt==0). Results hold and stim holds its last value. start here restarts exactly as from IDLE.
- start while busy: ignored; the sweep continues unchanged.
- rst asserted mid-sweep: the reset values apply on the next edge. A partial result is never reported.
- stim wrap: it never wraps inside a sweep; the terminal check happens before the increment.
- Outputs are registered. stim changes only on the DRIVE-entry edge, never in the same cycle the block samples.

Optional Feature:
- APPROX_ERR_SWEEP_SUM_EN
- Defined: adds output port err_sum, width OUT_W+IN_W. It is cleared on start and rst, and accumulates err every SAMPLE (sum of absolute errors for MAE). It is valid when done.
- Undefined: the port and its adder do not exist. All other behaviour is identical.

Test Plan:
- Loopback: bench drives dut_out = exact |A-B| of stim, start pulse -> done at cycle 32, max_err=0, viol_cnt=0, pass=1, worst_vec=0 (err_sum=0).
- Stuck-zero: dut_out=3'b000 -> max_err=3, worst_vec=4'h3 (A=3,B=0), viol_cnt=2, pass=0 (err_sum=20).
- Stuck-max: dut_out=3'b111 -> max_err=7, worst_vec=4'h0, viol_cnt=16, pass=0 (err_sum=92).
- Mid-sweep reset: assert rst for 1 cycle at cycle 10 of the sweep -> next cycle state IDLE, busy=0, done=0, all results 0. A new start then gives a full 32-cycle sweep with correct results.
- Start while busy: pulse start at cycles 5 and 17 of the sweep -> ignored; done still at cycle 32 with results identical to the single-start run.
- Restart from DONE: after a stuck-zero run, switch to loopback and pulse start -> results clear on the start cycle, and the final pass=1, max_err=0.
